// File: rtl/ppu_update_scheduler.sv
// Vblank-gated scheduler: buffers sprite/nametable updates and drains them onto one bus under a per-frame budget.
// Define PPU_SCHED_RR_EN for round-robin arbitration; otherwise the sprite FIFO has fixed priority.
module ppu_update_scheduler #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned WR_BUDGET  = 48
) (
  input  logic              clk_50MHz,
  input  logic              rst,
  input  logic              vblank,
  input  logic              spr_req,
  input  logic [5:0]        spr_addr,
  input  logic [DATA_W-1:0] spr_data,
  output logic              spr_full,
  input  logic              nt_req,
  input  logic [ADDR_W-1:0] nt_addr,
  input  logic [DATA_W-1:0] nt_data,
  output logic              nt_full,
  output logic              upd_valid,
  input  logic              upd_ready,
  output logic              upd_sel,
  output logic [ADDR_W-1:0] upd_addr,
  output logic [DATA_W-1:0] upd_data,
  output logic              frame_done,
  output logic              overrun,
  input  logic              overrun_clr
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BUD_W = $clog2(WR_BUDGET + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_HOLD  = 2'd2,
    S_CLOSE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [5:0]        spr_addr_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] spr_data_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] nt_addr_mem  [FIFO_DEPTH];
  logic [DATA_W-1:0] nt_data_mem  [FIFO_DEPTH];

  logic [PTR_W-1:0] spr_wr_ptr, spr_rd_ptr, nt_wr_ptr, nt_rd_ptr;
  logic [CNT_W-1:0] spr_cnt, spr_cnt_nxt, nt_cnt, nt_cnt_nxt;
  logic             spr_push, spr_pop, nt_push, nt_pop;
  logic             spr_avail, nt_avail;

  logic             vblank_d;
  logic [BUD_W-1:0] budget;
  logic             load, grant_nt, budget_init, close_done;

  assign spr_push  = spr_req & ~spr_full;
  assign nt_push   = nt_req & ~nt_full;
  assign spr_avail = (spr_cnt != '0);
  assign nt_avail  = (nt_cnt != '0);
  assign spr_pop   = load & ~grant_nt;
  assign nt_pop    = load & grant_nt;

`ifdef PPU_SCHED_RR_EN
  // Set after a sprite grant, so the sprite FIFO wins the first contested slot after reset.
  logic last_grant;
  assign grant_nt = nt_avail & (~spr_avail | last_grant);

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      last_grant <= 1'b0;
    end else if (load) begin
      last_grant <= ~grant_nt;
    end
  end
`else
  assign grant_nt = nt_avail & ~spr_avail;
`endif

  // State register, vblank edge detect and window budget
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      state    <= S_IDLE;
      vblank_d <= 1'b0;
      budget   <= '0;
    end else begin
      state    <= state_nxt;
      vblank_d <= vblank;
      if (budget_init) begin
        budget <= BUD_W'(WR_BUDGET);
      end else if (load) begin
        budget <= budget - BUD_W'(1);
      end
    end
  end

  // Next state and load control; loads stop the cycle vblank drops
  always_comb begin
    state_nxt   = state;
    load        = 1'b0;
    budget_init = 1'b0;
    close_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (vblank && !vblank_d) begin
          state_nxt   = S_DRAIN;
          budget_init = 1'b1;
        end
      end
      S_DRAIN: begin
        if (!vblank) begin
          state_nxt = S_CLOSE;
        end else begin
          load = (spr_avail || nt_avail) && (!upd_valid || upd_ready) && (budget != '0);
          if ((budget == '0) || (load && (budget == BUD_W'(1)))) begin
            state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!vblank) begin
          state_nxt = S_CLOSE;
        end
      end
      S_CLOSE: begin
        if (!upd_valid || upd_ready) begin
          close_done = 1'b1;
          state_nxt  = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    spr_cnt_nxt = spr_cnt;
    if (spr_push && !spr_pop) begin
      spr_cnt_nxt = spr_cnt + CNT_W'(1);
    end else if (!spr_push && spr_pop) begin
      spr_cnt_nxt = spr_cnt - CNT_W'(1);
    end
  end

  always_comb begin
    nt_cnt_nxt = nt_cnt;
    if (nt_push && !nt_pop) begin
      nt_cnt_nxt = nt_cnt + CNT_W'(1);
    end else if (!nt_push && nt_pop) begin
      nt_cnt_nxt = nt_cnt - CNT_W'(1);
    end
  end

  // FIFO pointers, occupancy and registered full flags
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      spr_wr_ptr <= '0;
      spr_rd_ptr <= '0;
      spr_cnt    <= '0;
      spr_full   <= 1'b0;
      nt_wr_ptr  <= '0;
      nt_rd_ptr  <= '0;
      nt_cnt     <= '0;
      nt_full    <= 1'b0;
    end else begin
      if (spr_push) spr_wr_ptr <= spr_wr_ptr + PTR_W'(1);
      if (spr_pop)  spr_rd_ptr <= spr_rd_ptr + PTR_W'(1);
      if (nt_push)  nt_wr_ptr  <= nt_wr_ptr + PTR_W'(1);
      if (nt_pop)   nt_rd_ptr  <= nt_rd_ptr + PTR_W'(1);
      spr_cnt  <= spr_cnt_nxt;
      nt_cnt   <= nt_cnt_nxt;
      spr_full <= (spr_cnt_nxt == CNT_W'(FIFO_DEPTH));
      nt_full  <= (nt_cnt_nxt == CNT_W'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (spr_push) begin
      spr_addr_mem[spr_wr_ptr] <= spr_addr;
      spr_data_mem[spr_wr_ptr] <= spr_data;
    end
    if (nt_push) begin
      nt_addr_mem[nt_wr_ptr] <= nt_addr;
      nt_data_mem[nt_wr_ptr] <= nt_data;
    end
  end

  // Output stage, frame pulse and sticky overrun
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      upd_valid  <= 1'b0;
      upd_sel    <= 1'b0;
      upd_addr   <= '0;
      upd_data   <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= close_done;
      if (close_done && (spr_avail || nt_avail)) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
      if (load) begin
        upd_valid <= 1'b1;
        upd_sel   <= grant_nt;
        upd_addr  <= grant_nt ? nt_addr_mem[nt_rd_ptr] : ADDR_W'(spr_addr_mem[spr_rd_ptr]);
        upd_data  <= grant_nt ? nt_data_mem[nt_rd_ptr] : spr_data_mem[spr_rd_ptr];
      end else if (upd_ready) begin
        upd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ppu_update_scheduler.sv
// Self-checking bench for ppu_update_scheduler: vector tables plus a beat scoreboard.
// A second instance with WR_BUDGET=2 shares the stimulus and is checked only in the budget test.
module tb_ppu_update_scheduler;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic              nt;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] exp_addr;
  } vec_t;

  typedef struct {
    logic              sel;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                cyc;
  } exp_t;

  logic              clk_50MHz = 1'b0;
  logic              rst = 1'b1;
  logic              vblank = 1'b0;
  logic              spr_req = 1'b0;
  logic [5:0]        spr_addr = '0;
  logic [DATA_W-1:0] spr_data = '0;
  logic              nt_req = 1'b0;
  logic [ADDR_W-1:0] nt_addr = '0;
  logic [DATA_W-1:0] nt_data = '0;
  logic              upd_ready = 1'b0;
  logic              overrun_clr = 1'b0;

  logic              spr_full, nt_full, upd_valid, upd_sel, frame_done, overrun;
  logic [ADDR_W-1:0] upd_addr;
  logic [DATA_W-1:0] upd_data;
  logic              b_spr_full, b_nt_full, b_upd_valid, b_upd_sel, b_frame_done, b_overrun;
  logic [ADDR_W-1:0] b_upd_addr;
  logic [DATA_W-1:0] b_upd_data;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   beats = 0;
  int   b_beats = 0;
  vec_t lat[3];
  vec_t rr[4];
  int   ord[4];

  always #10 clk_50MHz = ~clk_50MHz;

  ppu_update_scheduler dut (
    .clk_50MHz(clk_50MHz), .rst(rst), .vblank(vblank),
    .spr_req(spr_req), .spr_addr(spr_addr), .spr_data(spr_data), .spr_full(spr_full),
    .nt_req(nt_req), .nt_addr(nt_addr), .nt_data(nt_data), .nt_full(nt_full),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_sel(upd_sel),
    .upd_addr(upd_addr), .upd_data(upd_data),
    .frame_done(frame_done), .overrun(overrun), .overrun_clr(overrun_clr)
  );

  ppu_update_scheduler #(.WR_BUDGET(2)) dut_b (
    .clk_50MHz(clk_50MHz), .rst(rst), .vblank(vblank),
    .spr_req(spr_req), .spr_addr(spr_addr), .spr_data(spr_data), .spr_full(b_spr_full),
    .nt_req(nt_req), .nt_addr(nt_addr), .nt_data(nt_data), .nt_full(b_nt_full),
    .upd_valid(b_upd_valid), .upd_ready(upd_ready), .upd_sel(b_upd_sel),
    .upd_addr(b_upd_addr), .upd_data(b_upd_data),
    .frame_done(b_frame_done), .overrun(b_overrun), .overrun_clr(overrun_clr)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_50MHz);
    #1;
  endtask

  task automatic drive_push(input vec_t v);
    if (v.nt) begin
      nt_req  = 1'b1;
      nt_addr = v.addr;
      nt_data = v.data;
    end else begin
      spr_req  = 1'b1;
      spr_addr = v.addr[5:0];
      spr_data = v.data;
    end
    tick(1);
    spr_req = 1'b0;
    nt_req  = 1'b0;
  endtask

  task automatic expect_beat(input vec_t v, input int c);
    exp_t e;
    e.sel  = v.nt;
    e.addr = v.exp_addr;
    e.data = v.data;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    vblank      = 1'b0;
    spr_req     = 1'b0;
    nt_req      = 1'b0;
    upd_ready   = 1'b0;
    overrun_clr = 1'b0;
    exp_q.delete();
    tick(2);
    rst = 1'b0;
  endtask

  task automatic wait_empty(input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      tick(1);
      n++;
    end
    check("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_valid(input int limit);
    int n = 0;
    while (!upd_valid && n < limit) begin
      tick(1);
      n++;
    end
    check("wait_valid", 64'(upd_valid), 64'd1);
  endtask

  task automatic close_window(input logic exp_ovr);
    vblank = 1'b0;
    tick(1); @(negedge clk_50MHz);
    check("frame_done_f1", 64'(frame_done), 64'd0);
    tick(1); @(negedge clk_50MHz);
    check("frame_done_f2", 64'(frame_done), 64'd1);
    check("overrun_close", 64'(overrun), 64'(exp_ovr));
    tick(1); @(negedge clk_50MHz);
    check("frame_done_f3", 64'(frame_done), 64'd0);
    tick(1);
  endtask

  // Compares every valid beat with the scoreboard head; pops on acceptance
  task automatic monitor();
    forever begin
      @(negedge clk_50MHz);
      if (!rst && upd_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got sel=%0d addr=0x%0h data=0x%0h, required no beat",
                   upd_sel, upd_addr, upd_data);
        end else begin
          check("beat", 64'({upd_sel, upd_addr, upd_data}),
                64'({exp_q[0].sel, exp_q[0].addr, exp_q[0].data}));
          if (upd_ready) begin
            if (exp_q[0].cyc >= 0) check("beat_cycle", 64'(cyc), 64'(exp_q[0].cyc));
            exp_q.delete(0);
          end
        end
        if (upd_ready) beats++;
      end
      if (!rst && b_upd_valid && upd_ready) b_beats++;
    end
  endtask

  initial begin
    vec_t v;

    lat[0] = '{nt: 1'b0, addr: 10'h000, data: 32'h1111_0000, exp_addr: 10'h000};
    lat[1] = '{nt: 1'b0, addr: 10'h001, data: 32'h1111_0001, exp_addr: 10'h001};
    lat[2] = '{nt: 1'b0, addr: 10'h002, data: 32'h1111_0002, exp_addr: 10'h002};
    rr[0]  = '{nt: 1'b0, addr: 10'h003, data: 32'hA000_0001, exp_addr: 10'h003};
    rr[1]  = '{nt: 1'b1, addr: 10'h155, data: 32'hB000_0001, exp_addr: 10'h155};
    rr[2]  = '{nt: 1'b0, addr: 10'h03F, data: 32'hA000_0002, exp_addr: 10'h03F};
    rr[3]  = '{nt: 1'b1, addr: 10'h3FF, data: 32'hB000_0002, exp_addr: 10'h3FF};
`ifdef PPU_SCHED_RR_EN
    ord[0] = 0; ord[1] = 1; ord[2] = 2; ord[3] = 3;
`else
    ord[0] = 0; ord[1] = 2; ord[2] = 1; ord[3] = 3;
`endif

    fork
      monitor();
      forever begin
        @(posedge clk_50MHz);
        cyc++;
      end
      begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
      end
    join_none

    // Reset state
    do_reset();
    @(negedge clk_50MHz);
    check("reset_outputs", 64'({spr_full, nt_full, upd_valid, upd_sel, upd_addr, upd_data, frame_done, overrun}), 64'd0);
    tick(1);

    // Latency: three sprite pushes during DRAIN appear at N+2..N+4
    vblank = 1'b1;
    tick(2);
    upd_ready = 1'b1;
    beats = 0;
    for (int i = 0; i < 3; i++) begin
      expect_beat(lat[i], cyc + 2);
      drive_push(lat[i]);
    end
    wait_empty(20);
    check("lat_beats", 64'(beats), 64'd3);
    close_window(1'b0);

    // Arbitration order with both FIFOs loaded before the window opens
    do_reset();
    beats = 0;
    upd_ready = 1'b1;
    for (int i = 0; i < 4; i++) drive_push(rr[i]);
    vblank = 1'b1;
    for (int i = 0; i < 4; i++) expect_beat(rr[ord[i]], cyc + 2 + i);
    wait_empty(20);
    check("arb_beats", 64'(beats), 64'd4);
    close_window(1'b0);

    // Budget of 2 on dut_b: two beats, then overrun at close
    do_reset();
    beats = 0;
    b_beats = 0;
    upd_ready = 1'b1;
    for (int i = 0; i < 4; i++) drive_push(rr[i]);
    vblank = 1'b1;
    for (int i = 0; i < 4; i++) expect_beat(rr[ord[i]], -1);
    wait_empty(20);
    tick(3);
    check("budget_beats", 64'(b_beats), 64'd2);
    check("budget_hold_idle", 64'(b_upd_valid), 64'd0);
    vblank = 1'b0;
    tick(1); @(negedge clk_50MHz);
    check("budget_frame_done_f1", 64'(b_frame_done), 64'd0);
    tick(1); @(negedge clk_50MHz);
    check("budget_frame_done_f2", 64'(b_frame_done), 64'd1);
    check("budget_overrun", 64'(b_overrun), 64'd1);
    check("main_frame_done", 64'(frame_done), 64'd1);
    check("main_overrun", 64'(overrun), 64'd0);
    tick(1);
    overrun_clr = 1'b1;
    tick(1);
    overrun_clr = 1'b0;
    @(negedge clk_50MHz);
    check("overrun_cleared", 64'(b_overrun), 64'd0);
    tick(1);

    // Backpressure across window close: beat holds, frame_done follows acceptance
    do_reset();
    vblank = 1'b1;
    tick(2);
    v = '{nt: 1'b0, addr: 10'h02A, data: 32'hDEAD_BEEF, exp_addr: 10'h02A};
    expect_beat(v, -1);
    drive_push(v);
    wait_valid(10);
    vblank = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_50MHz);
      check("bp_frame_done_held", 64'(frame_done), 64'd0);
      tick(1);
    end
    upd_ready = 1'b1;
    @(negedge clk_50MHz);
    tick(1); @(negedge clk_50MHz);
    check("bp_frame_done", 64'(frame_done), 64'd1);
    check("bp_valid_dropped", 64'(upd_valid), 64'd0);
    check("bp_overrun", 64'(overrun), 64'd0);
    tick(1); @(negedge clk_50MHz);
    check("bp_frame_done_end", 64'(frame_done), 64'd0);
    check("bp_pending", 64'(exp_q.size()), 64'd0);
    tick(1);

    // Full FIFO: fifth push refused, only four beats next window
    do_reset();
    beats = 0;
    upd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      v.nt       = 1'b0;
      v.addr     = 10'(16 + i);
      v.data     = 32'hC000_0000 + 32'(i);
      v.exp_addr = 10'(16 + i);
      if (i < 4) expect_beat(v, -1);
      spr_req  = 1'b1;
      spr_addr = v.addr[5:0];
      spr_data = v.data;
      @(negedge clk_50MHz);
      check("full_flag", 64'(spr_full), (i == 4) ? 64'd1 : 64'd0);
      tick(1);
    end
    spr_req = 1'b0;
    @(negedge clk_50MHz);
    check("full_flag_hold", 64'(spr_full), 64'd1);
    tick(1);
    vblank = 1'b1;
    wait_empty(20);
    tick(4);
    check("full_beats", 64'(beats), 64'd4);
    check("full_flag_drained", 64'(spr_full), 64'd0);

    // Reset mid-drain with a beat in flight
    do_reset();
    beats = 0;
    vblank = 1'b1;
    tick(2);
    v = '{nt: 1'b0, addr: 10'h015, data: 32'h5555_AAAA, exp_addr: 10'h015};
    expect_beat(v, -1);
    drive_push(v);
    wait_valid(10);
    v = '{nt: 1'b1, addr: 10'h2C3, data: 32'h7777_0000, exp_addr: 10'h2C3};
    drive_push(v);
    rst = 1'b1;
    exp_q.delete();
    tick(1);
    rst = 1'b0;
    @(negedge clk_50MHz);
    check("rst_mid_outputs", 64'({spr_full, nt_full, upd_valid, upd_sel, upd_addr, upd_data, frame_done, overrun}), 64'd0);
    tick(1);
    upd_ready = 1'b1;
    tick(8);
    check("rst_mid_no_beats", 64'(beats), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ppu_update_scheduler.md
# ppu_update_scheduler

Vblank-gated write scheduler for PPU memory updates. Buffers CPU-side sprite-RAM and nametable update requests in two small FIFOs. Drains them onto one shared update bus only while the renderer is in vertical blank, subject to a per-frame write budget. It sits between the AHB-facing register logic and the PPU memory write ports, so CPU writes never collide with scanline fetches.

## Interface
Parameters:
- `FIFO_DEPTH`, 4 — entries per requester FIFO; power of 2, minimum 2.
- `ADDR_W`, 10 — update address width; sprite addresses are zero-extended from 6 bits.
- `DATA_W`, 32 — update data width.
- `WR_BUDGET`, 48 — maximum beats loaded onto the update bus per vblank window.

Ports:
- `clk_50MHz`  in  1  — system clock.
- `rst`  in  1  — reset, synchronous, active-high.
- `vblank`  in  1  — level; high while the renderer is not reading PPU memories.
- `spr_req`  in  1  — sprite update request; accepted when `spr_req & ~spr_full`.
- `spr_addr`  in  6  — sprite RAM entry index.
- `spr_data`  in  DATA_W  — sprite entry word.
- `spr_full`  out  1  — sprite FIFO full (registered).
- `nt_req`  in  1  — nametable update request; accepted when `nt_req & ~nt_full`.
- `nt_addr`  in  ADDR_W  — nametable index.
- `nt_data`  in  DATA_W  — nametable word.
- `nt_full`  out  1  — nametable FIFO full (registered).
- `upd_valid`  out  1  — update beat valid.
- `upd_ready`  in  1  — downstream accepts the beat.
- `upd_sel`  out  1  — target select: 0 = sprite RAM, 1 = nametable.
- `upd_addr`  out  ADDR_W  — update address.
- `upd_data`  out  DATA_W  — update data.
- `frame_done`  out  1  — one-cycle pulse when a vblank window closes.
- `overrun`  out  1  — sticky; set when a window closes with entries still pending.
- `overrun_clr`  in  1  — clears `overrun`.

## Operation
- FIFO push:
  - A request is written on the edge that ends the accepting cycle.
  - `*_full` is evaluated at the start of the cycle, so a push to a full FIFO is refused even if a pop happens in the same cycle.
- Output stage:
  - A single register holds `upd_*`.
  - It loads when it is empty, or when its current beat is being accepted (`upd_valid & upd_ready`) in that cycle.
  - Once `upd_valid` is high, `upd_sel`, `upd_addr` and `upd_data` stay stable until the beat is accepted.
- State machine (`vblank_d` is `vblank` registered):
  - **IDLE**: no loads. On `vblank & ~vblank_d`, go to DRAIN and load the budget counter with `WR_BUDGET`.
  - **DRAIN**: on each load, pop one FIFO and decrement the budget. The winner is chosen by the arbiter below.
    - Budget reaches 0 → HOLD.
    - `~vblank` → CLOSE.
  - **HOLD**: no loads. `~vblank` → CLOSE.
  - **CLOSE**: no loads.
    - If `upd_valid` is high, wait for acceptance; the beat is still delivered even though it is outside vblank.
    - Then pulse `frame_done`, set `overrun` if either FIFO is non-empty, and go to IDLE.
- Arbiter, used only when both FIFOs are non-empty:
  - Grant goes to the requester not granted last. `last_grant` updates on every load.
  - With one FIFO non-empty, that FIFO is granted.
- Budget counter:
  - Width is `$clog2(WR_BUDGET+1)`.
  - It never underflows, and it is not reloaded mid-window.
- `overrun`:
  - When a set and `overrun_clr` occur in the same cycle, the set wins.
- Reset:
  - State goes to IDLE and FIFOs empty; the budget counter, `last_grant` and `vblank_d` all clear.
  - Every output goes to 0, including `spr_full`, `nt_full`, `upd_*`, `frame_done` and `overrun`.
  - A beat in flight is discarded; no acceptance is required.

## Timing
- Latency, with state DRAIN, empty FIFO, empty output stage and budget available:
  - Request accepted in cycle N.
  - Entry visible in cycle N+1 and loaded at the end of N+1.
  - `upd_valid` is high in N+2.
- Throughput: one beat per cycle while `upd_ready` is held high and entries are available.
- First load after a vblank rising edge:
  - `vblank` rises in cycle V and DRAIN is entered at the end of V.
  - The first load happens at the end of V+1, so `upd_valid` is high in V+2.
- `vblank` falling in cycle F:
  - No new load occurs at the end of F.
  - With no beat in flight, CLOSE is entered at the end of F and `frame_done` pulses in F+2.
- `*_full` updates one cycle after the push or pop that changes the FIFO occupancy.

## Configuration
- `PPU_SCHED_RR_EN` defined: round-robin arbitration, as described under Operation.
- Undefined: fixed priority, sprite FIFO always wins; `last_grant` is not implemented.

## Test plan
- **Latency:** vblank held high, 3 sprite pushes at addresses 0,1,2 with `upd_ready`=1 → `upd_valid` in cycles N+2..N+4, `upd_sel`=0, addresses 0,1,2 in order.
- **Round-robin (macro on):** 2 sprite + 2 nametable entries queued before the vblank rising edge → `upd_sel` sequence 0,1,0,1. With the macro off → 0,0,1,1.
- **Budget:** `WR_BUDGET`=2, 4 entries queued, one vblank window → exactly 2 beats, HOLD entered; at window close `frame_done`=1 and `overrun`=1.
- **Backpressure across close:** `upd_ready`=0 while `vblank` falls with a beat valid → beat holds stable; `frame_done` pulses 1 cycle after `upd_ready`=1 acceptance.
- **Full FIFO:** 5 sprite pushes with `vblank`=0 and depth 4 → `spr_full`=1 after the 4th, 5th refused; only 4 beats emitted next window.
- **Reset mid-drain:** `rst` asserted during DRAIN with `upd_valid`=1 → next cycle all outputs 0, FIFOs empty, state IDLE.
